// File: rtl/mxrv_ibus_mem_if.sv
// Fetch-side bus between the mxrv fetch stage (master) and the instruction responder (slave).
interface mxrv_ibus_mem_if;
    logic        req_i;
    logic [31:0] addr_i;
    logic        gnt_o;
    logic        rvalid_o;
    logic [31:0] rdata_o;
    logic        err_o;
    logic        busy_o;

    modport master (
        output req_i,
        output addr_i,
        input  gnt_o,
        input  rvalid_o,
        input  rdata_o,
        input  err_o,
        input  busy_o
    );

    modport slave (
        input  req_i,
        input  addr_i,
        output gnt_o,
        output rvalid_o,
        output rdata_o,
        output err_o,
        output busy_o
    );
endinterface

// File: rtl/mxrv_ibus_mem.sv
// Instruction-side bus responder: one word per granted fetch after WAIT wait states,
// NOP + error for misaligned/out-of-range fetches, side-band program-load port.
module mxrv_ibus_mem #(
    parameter int DEPTH  = 1024,
    parameter int ADDR_W = 10,
    parameter int WAIT   = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    mxrv_ibus_mem_if.slave    bus,
    input  logic              ld_we_i,
    input  logic [ADDR_W-1:0] ld_addr_i,
    input  logic [31:0]       ld_data_i
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_RESP = 2'd2
    } state_t;

    localparam logic [31:0] NOP_WORD  = 32'h0000_0013;
    localparam logic [2:0]  WAIT_CNT  = 3'(WAIT);
    localparam logic        ZERO_WAIT = (WAIT == 0);

    state_t      r_state;
    logic [2:0]  r_cnt;
    logic [31:0] r_addr;
    logic [31:0] r_rdata;
    logic        r_err;
    logic [31:0] r_mem [DEPTH];

    logic              w_gnt;
    logic              w_enter_resp;
    logic [31:0]       w_fetch_addr;
    logic              w_err;
    logic [ADDR_W-1:0] w_idx;

    // Loads win over grants; gating with rst_n keeps gnt low while reset is held.
    assign w_gnt = rst_n & bus.req_i & ~ld_we_i &
                   ((r_state == S_IDLE) | (r_state == S_RESP));

    // With zero wait states the response is formed on the accept edge itself,
    // so the address must come straight from the bus rather than the latch.
    assign w_enter_resp = (w_gnt & ZERO_WAIT) | ((r_state == S_WAIT) & (r_cnt == 3'd1));
    assign w_fetch_addr = (w_gnt & ZERO_WAIT) ? bus.addr_i : r_addr;
    assign w_err        = (|w_fetch_addr[1:0]) | (w_fetch_addr[31:2] >= 30'(DEPTH));
    assign w_idx        = w_fetch_addr[ADDR_W+1:2];

    // NOTE: the array has no reset so it maps onto plain RAM; only control state is reset.
    always_ff @(posedge clk) begin
        if (ld_we_i) begin
            r_mem[ld_addr_i] <= ld_data_i;
        end
    end

    // NOTE: non-blocking reads of r_mem see the pre-edge contents, which gives
    // read-before-write when a load hits the word being returned on the same edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
            r_cnt   <= 3'd0;
            r_addr  <= 32'd0;
            r_rdata <= 32'd0;
            r_err   <= 1'b0;
        end else begin
            if (w_enter_resp) begin
                r_err   <= w_err;
                r_rdata <= w_err ? NOP_WORD : r_mem[w_idx];
            end
            case (r_state)
                S_IDLE, S_RESP: begin
                    if (w_gnt) begin
                        r_addr  <= bus.addr_i;
                        r_cnt   <= WAIT_CNT;
                        r_state <= ZERO_WAIT ? S_RESP : S_WAIT;
                    end else begin
                        r_state <= S_IDLE;
                    end
                end
                S_WAIT: begin
                    r_cnt <= r_cnt - 3'd1;
                    if (r_cnt == 3'd1) begin
                        r_state <= S_RESP;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign bus.gnt_o    = w_gnt;
    assign bus.rvalid_o = (r_state == S_RESP);
    assign bus.rdata_o  = r_rdata;
    assign bus.err_o    = r_err;
    assign bus.busy_o   = (r_state != S_IDLE);

endmodule

// File: tb/tb_mxrv_ibus_mem.sv
// Scoreboard bench for mxrv_ibus_mem: three instances (WAIT=1, 0, 3) share clock and reset.
module tb_mxrv_ibus_mem;

    typedef struct packed {
        logic [31:0] cyc;
        logic        err;
        logic [31:0] data;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n;
    int unsigned cyc = 0;
    int n_checks = 0;
    int n_fail   = 0;

    logic        req     [3];
    logic [31:0] addr    [3];
    logic        ld_we   [3];
    logic [9:0]  ld_addr [3];
    logic [31:0] ld_data [3];
    logic        gnt     [3];
    logic        rvalid  [3];
    logic [31:0] rdata   [3];
    logic        err     [3];
    logic        busy    [3];

    exp_t exp_q [3][$];
    exp_t mon_e;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic int wait_of(input int g);
        return (g == 0) ? 1 : ((g == 1) ? 0 : 3);
    endfunction

    for (genvar g = 0; g < 3; g++) begin : g_dut
        mxrv_ibus_mem_if bus ();
        assign bus.req_i  = req[g];
        assign bus.addr_i = addr[g];
        assign gnt[g]     = bus.gnt_o;
        assign rvalid[g]  = bus.rvalid_o;
        assign rdata[g]   = bus.rdata_o;
        assign err[g]     = bus.err_o;
        assign busy[g]    = bus.busy_o;

        mxrv_ibus_mem #(
            .DEPTH (1024),
            .ADDR_W(10),
            .WAIT  ((g == 0) ? 1 : ((g == 1) ? 0 : 3))
        ) u_dut (
            .clk      (clk),
            .rst_n    (rst_n),
            .bus      (bus.slave),
            .ld_we_i  (ld_we[g]),
            .ld_addr_i(ld_addr[g]),
            .ld_data_i(ld_data[g])
        );
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic load(input int g, input logic [9:0] idx, input logic [31:0] d);
        ld_we[g]   = 1'b1;
        ld_addr[g] = idx;
        ld_data[g] = d;
        step();
        ld_we[g]   = 1'b0;
    endtask

    task automatic push_exp(input int g, input int lat, input logic e, input logic [31:0] d);
        exp_t t;
        t.cyc  = cyc + 32'(lat);
        t.err  = e;
        t.data = d;
        exp_q[g].push_back(t);
    endtask

    // Single-cycle request; expects an immediate grant.
    task automatic fetch(input int g, input logic [31:0] a, input logic e, input logic [31:0] d);
        req[g]  = 1'b1;
        addr[g] = a;
        #1;
        check($sformatf("gnt[%0d] @%h", g, a), 64'(gnt[g]), 64'd1);
        push_exp(g, 1 + wait_of(g), e, d);
        step();
        req[g] = 1'b0;
    endtask

    task automatic drain(input int g);
        int k = 0;
        while (exp_q[g].size() != 0 && k < 20) begin
            step();
            k++;
        end
        check($sformatf("drain[%0d]", g), 64'(exp_q[g].size()), 64'd0);
    endtask

    // Monitor: every presented response is matched against the head of its queue.
    always @(negedge clk) begin
        for (int g = 0; g < 3; g++) begin
            if (rvalid[g] === 1'b1) begin
                if (exp_q[g].size() == 0) begin
                    check($sformatf("unexpected_rvalid[%0d]", g), 64'd1, 64'd0);
                end else begin
                    mon_e = exp_q[g].pop_front();
                    check($sformatf("resp_cycle[%0d]", g), 64'(cyc), 64'(mon_e.cyc));
                    check($sformatf("resp_err[%0d]", g), 64'(err[g]), 64'(mon_e.err));
                    check($sformatf("resp_data[%0d]", g), 64'(rdata[g]), 64'(mon_e.data));
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0;
        for (int g = 0; g < 3; g++) begin
            req[g] = 1'b1; addr[g] = 32'h0;
            ld_we[g] = 1'b0; ld_addr[g] = 10'd0; ld_data[g] = 32'd0;
        end
        step();
        step();
        for (int g = 0; g < 3; g++) begin
            check($sformatf("rst_gnt[%0d]", g), 64'(gnt[g]), 64'd0);
            check($sformatf("rst_rvalid[%0d]", g), 64'(rvalid[g]), 64'd0);
            check($sformatf("rst_rdata[%0d]", g), 64'(rdata[g]), 64'd0);
            check($sformatf("rst_err[%0d]", g), 64'(err[g]), 64'd0);
            check($sformatf("rst_busy[%0d]", g), 64'(busy[g]), 64'd0);
            req[g] = 1'b0;
        end
        rst_n = 1'b1;
        step();

        // Preload program words.
        load(0, 10'd4, 32'hDEAD_BEEF);
        load(0, 10'd8, 32'h0BAD_0008);
        load(0, 10'd1023, 32'h7777_0FFC);
        load(1, 10'd0, 32'd1);
        load(1, 10'd1, 32'd2);
        load(1, 10'd2, 32'd3);
        load(2, 10'd5, 32'h1111_1111);

        // WAIT=1: basic fetch, latency, busy window, data hold.
        check("busy_before", 64'(busy[0]), 64'd0);
        fetch(0, 32'h10, 1'b0, 32'hDEAD_BEEF);
        check("busy_n1", 64'(busy[0]), 64'd1);
        step();
        check("busy_n2", 64'(busy[0]), 64'd1);
        step();
        check("busy_n3", 64'(busy[0]), 64'd0);
        check("rdata_hold", 64'(rdata[0]), 64'hDEAD_BEEF);
        drain(0);

        // WAIT=0: back-to-back grants, one response per cycle.
        for (int i = 0; i < 3; i++) begin
            req[1]  = 1'b1;
            addr[1] = 32'(i * 4);
            #1;
            check($sformatf("b2b_gnt%0d", i), 64'(gnt[1]), 64'd1);
            push_exp(1, 1, 1'b0, 32'(i + 1));
            step();
        end
        req[1] = 1'b0;
        drain(1);

        // Error and range boundaries.
        fetch(0, 32'h0000_0006, 1'b1, 32'h0000_0013);
        drain(0);
        fetch(0, 32'h0000_1000, 1'b1, 32'h0000_0013);
        drain(0);
        fetch(0, 32'h0000_0FFC, 1'b0, 32'h7777_0FFC);
        drain(0);
        fetch(0, 32'hFFFF_FFFC, 1'b1, 32'h0000_0013);
        drain(0);

        // Load has priority over grant; the following grant sees the new word.
        req[0] = 1'b1; addr[0] = 32'h20;
        ld_we[0] = 1'b1; ld_addr[0] = 10'd8; ld_data[0] = 32'hCAFE_0008;
        #1;
        check("ld_blocks_gnt", 64'(gnt[0]), 64'd0);
        step();
        ld_we[0] = 1'b0;
        #1;
        check("gnt_after_ld", 64'(gnt[0]), 64'd1);
        push_exp(0, 2, 1'b0, 32'hCAFE_0008);
        step();
        req[0] = 1'b0;
        drain(0);

        // WAIT=3: load lands on the edge entering RESP -> old word, then new word.
        fetch(2, 32'h14, 1'b0, 32'h1111_1111);
        step();
        step();
        ld_we[2] = 1'b1; ld_addr[2] = 10'd5; ld_data[2] = 32'h2222_2222;
        step();
        ld_we[2] = 1'b0;
        drain(2);
        fetch(2, 32'h14, 1'b0, 32'h2222_2222);
        drain(2);

        // WAIT=3: reset one cycle after grant abandons the fetch.
        req[2] = 1'b1; addr[2] = 32'h14;
        #1;
        check("rst_mid_gnt", 64'(gnt[2]), 64'd1);
        step();
        req[2] = 1'b0;
        check("rst_mid_busy_pre", 64'(busy[2]), 64'd1);
        check("rst_mid_rdata_pre", 64'(rdata[2]), 64'h2222_2222);
        rst_n = 1'b0;
        #1;
        check("rst_mid_busy", 64'(busy[2]), 64'd0);
        check("rst_mid_rvalid", 64'(rvalid[2]), 64'd0);
        check("rst_mid_rdata", 64'(rdata[2]), 64'd0);
        check("rst_mid_err", 64'(err[2]), 64'd0);
        step();
        rst_n = 1'b1;
        repeat (8) step();
        check("rst_mid_idle", 64'(busy[2]), 64'd0);
        fetch(2, 32'h14, 1'b0, 32'h2222_2222);
        drain(2);

        for (int g = 0; g < 3; g++) begin
            check($sformatf("final_q[%0d]", g), 64'(exp_q[g].size()), 64'd0);
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/mxrv_ibus_mem.md
# mxrv_ibus_mem

Instruction-side bus responder for the mxrv core. It answers instruction fetch requests issued by the fetch stage (pc used directly as the byte address), returns one 32-bit instruction word per accepted request after a configurable number of wait states, and flags misaligned or out-of-range fetches. A side-band load port preloads program words. It sits between the fetch stage and the instruction storage array.

## Interface

Parameters:
- `DEPTH`, 1024: number of 32-bit instruction words stored.
- `ADDR_W`, 10: word-index width; equals log2(DEPTH).
- `WAIT`, 1: wait states between accept and response; legal range 0..7.

Ports:
- `clk`  in  1  single clock; all state updates on the rising edge.
- `rst_n`  in  1  reset, asynchronous assert, active-low.
- `req_i`  in  1  fetch request from the fetch stage.
- `addr_i`  in  32  fetch byte address (pc value).
- `gnt_o`  out  1  request accepted this cycle (combinational).
- `rvalid_o`  out  1  response valid, one-cycle pulse per accepted request.
- `rdata_o`  out  32  instruction word; held until the next response.
- `err_o`  out  1  response error; valid only with `rvalid_o`.
- `busy_o`  out  1  a fetch is in flight (state not IDLE).
- `ld_we_i`  in  1  program-load write strobe.
- `ld_addr_i`  in  ADDR_W  program-load word index.
- `ld_data_i`  in  32  program-load data.

## Operation

- FSM states: IDLE, WAIT, RESP.
- `gnt_o = req_i & ~ld_we_i & (state==IDLE | state==RESP)`.
- Accept (gnt_o=1): latch `addr_i`, load wait counter with `WAIT`. Next state: RESP if WAIT==0, else WAIT.
- WAIT: counter decrements each cycle; the cycle it equals 1, next state is RESP.
- On the edge entering RESP: `rdata_o`/`err_o` are registered from the latched address.
- RESP: `rvalid_o`=1 for exactly one cycle. Next state: per accept rules if a new request is granted, else IDLE.
- Error: `addr[1:0]!=0` or `addr[31:2] >= DEPTH` -> `err_o`=1, `rdata_o`=32'h0000_0013 (NOP); no array access.
- Normal: `err_o`=0, `rdata_o`=mem[addr[ADDR_W+1:2]].
- Load: `ld_we_i`=1 writes `ld_data_i` to mem[`ld_addr_i`] on the edge, in any state. Load has priority over grant. A load does not disturb an in-flight fetch.
- Same-edge load and response read of the same word: old data returned (read-before-write). Any later fetch sees the new data.
- `busy_o`=1 whenever state != IDLE.

## Timing

- Reset values: state IDLE, `rvalid_o`=0, `err_o`=0, `rdata_o`=0, `busy_o`=0, counter=0. Array contents are not reset.
- `gnt_o` follows `req_i` combinationally when eligible; it is 0 during reset.
- Latency: request granted in cycle N -> `rvalid_o` in cycle N+1+WAIT.
- Throughput: one response every WAIT+1 cycles with back-to-back grants in RESP.
- Reset asserted mid-fetch: fetch abandoned, no `rvalid_o` after release, outputs return to reset values immediately (async).
- `rdata_o` and `err_o` are stable from the RESP cycle until the next RESP cycle.
- Request held while not granted: no side effects. The requester keeps `addr_i` until it sees `gnt_o`.

## Test plan

- WAIT=1; load mem[4]=32'hDEAD_BEEF; req at addr 0x10 in cycle N -> gnt in N, `rvalid_o`=1, `rdata_o`=DEAD_BEEF, `err_o`=0 in N+2; `busy_o` high N+1..N+2.
- WAIT=0; continuous req at 0x0, 0x4, 0x8 (preloaded 1,2,3) -> gnt every cycle, rvalid every cycle from N+1, data 1,2,3 in order.
- Misaligned 0x6 and out-of-range 0x1000 (DEPTH=1024) -> `rvalid_o`=1, `err_o`=1, `rdata_o`=0x0000_0013 for each.
- req with `ld_we_i`=1 in IDLE -> `gnt_o`=0 that cycle; write lands; next cycle grant, response returns newly loaded word.
- WAIT=3; load to the fetched word on the edge entering RESP -> old word returned; repeat fetch returns new word.
- WAIT=3; assert `rst_n`=0 one cycle after grant -> `busy_o`, `rvalid_o`, `rdata_o` go 0 immediately; no response after release; next request served normally.
